// File: rtl/serial_alu.sv
// Bit-serial ALU: AND/OR/XOR/NOR/ADD/SUB/PASS on W-bit operands, one bit per clock, LSB first.
// Latency: W cycles from the accepting edge to done; one op every W+1 cycles when back-to-back.
// Backpressure: start is accepted only while busy=0 (IDLE or DONE); start during RUN is ignored.
module serial_alu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic [2:0]   ALOP,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         zero
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_PASA = 3'b110;
  localparam logic [2:0] OP_PASB = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res_sh;
  logic [2:0]    op;
  logic          carry;
  logic [CW-1:0] cnt;

  logic          arith;
  logic          b_eff;
  logic          bit_res;
  logic          carry_nxt;
  logic [W-1:0]  res_nxt;

  // One bit-slice of the ALU acting on the current LSBs; the carry flop stands in for the ripple chain.
  always_comb begin
    arith     = op[2] & ~op[1];
    b_eff     = (op == OP_SUB) ? ~b_sh[0] : b_sh[0];
    carry_nxt = (a_sh[0] & b_eff) | (a_sh[0] & carry) | (b_eff & carry);
    bit_res   = 1'b0;
    case (op)
      OP_AND:  bit_res = a_sh[0] & b_sh[0];
      OP_OR:   bit_res = a_sh[0] | b_sh[0];
      OP_XOR:  bit_res = a_sh[0] ^ b_sh[0];
      OP_NOR:  bit_res = ~(a_sh[0] | b_sh[0]);
      OP_ADD:  bit_res = a_sh[0] ^ b_eff ^ carry;
      OP_SUB:  bit_res = a_sh[0] ^ b_eff ^ carry;
      OP_PASA: bit_res = a_sh[0];
      OP_PASB: bit_res = b_sh[0];
      default: bit_res = 1'b0;
    endcase
    // Result bits enter at the MSB so that after W steps bit 0 holds the first-computed bit.
    res_nxt = {bit_res, res_sh[W-1:1]};
  end

  // Control FSM plus datapath registers; outputs only update on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            op     <= ALOP;
            carry  <= c_in;
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          if (arith) begin
            carry <= carry_nxt;
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= res_nxt;
            c_out  <= arith & carry_nxt;
            zero   <= (res_nxt == '0);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu at W=8 against an arithmetic reference model.
// Latency checked at exactly W cycles per op; back-to-back spacing checked at W+1.
// Stimulus is driven 1 time unit after posedge and sampled in that same phase.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [2:0]   alop;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         zero;

  int errors = 0;
  int checks = 0;

  serial_alu #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .ALOP   (alop),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: {carry, result} from plain W-bit arithmetic and bitwise operators.
  function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] av,
                                       input logic [W-1:0] bv, input logic cin);
    logic [W-1:0] nb;
    nb = ~bv;
    case (op)
      3'd0: model = {1'b0, av & bv};
      3'd1: model = {1'b0, av | bv};
      3'd2: model = {1'b0, av ^ bv};
      3'd3: model = {1'b0, ~(av | bv)};
      3'd4: model = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cin};
      3'd5: model = {1'b0, av} + {1'b0, nb} + {{W{1'b0}}, cin};
      3'd6: model = {1'b0, av};
      default: model = {1'b0, bv};
    endcase
  endfunction

  // Issue one op and wait (bounded) for done; lat = edges from accept to done.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cin, output int lat, output int bcyc);
    int guard;
    guard = 0;
    while (busy === 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    alop = op; a = av; b = bv; c_in = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); alop = 3'($urandom);
    lat = 0;
    bcyc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) bcyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0; alop = '0;
    #2;
    checks++;
    if ({busy, done, result, c_out, zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h c_out=%b zero=%b, all must be 0",
               busy, done, result, c_out, zero);
    end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_add_boundary;
    int lat, bcyc;
    do_op(3'd4, 8'hFF, 8'h01, 1'b0, lat, bcyc);
    checks++;
    if (lat !== W) begin errors++; $display("FAIL add_latency: got %0d expected %0d", lat, W); end
    checks++;
    if (bcyc !== W) begin errors++; $display("FAIL add_busy_cycles: got %0d expected %0d", bcyc, W); end
    checks++;
    if (result !== 8'h00 || c_out !== 1'b1 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_ff_01: got result=%h c_out=%b zero=%b expected 00 1 1", result, c_out, zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || result !== 8'h00) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b result=%h expected done=0 result=00", done, result);
    end
  endtask

  task automatic test_sub;
    int lat, bcyc;
    do_op(3'd5, 8'h05, 8'h07, 1'b1, lat, bcyc);
    checks++;
    if (result !== 8'hFE || c_out !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_5_7: got result=%h c_out=%b zero=%b expected fe 0 0", result, c_out, zero);
    end
    do_op(3'd5, 8'h07, 8'h05, 1'b1, lat, bcyc);
    checks++;
    if (result !== 8'h02 || c_out !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_7_5: got result=%h c_out=%b zero=%b expected 02 1 0", result, c_out, zero);
    end
  endtask

  task automatic test_logic;
    int lat, bcyc;
    logic [2:0] ops [6];
    logic [W-1:0] exp_r [6];
    ops   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    exp_r = '{8'h48, 8'hDE, 8'h96, 8'h21, 8'hCA, 8'h5C};
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], 8'hCA, 8'h5C, 1'b1, lat, bcyc);
      checks++;
      if (result !== exp_r[i] || c_out !== 1'b0) begin
        errors++;
        $display("FAIL logic_op%0d: got result=%h c_out=%b expected %h 0", ops[i], result, c_out, exp_r[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int n_done, first_done;
    @(posedge clk); #1;
    alop = 3'd4; a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0; first_done = -1;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin alop = 3'd5; a = 8'hFF; b = 8'h0F; c_in = 1'b1; start = 1'b1; end
      if (i == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
    end
    checks++;
    if (n_done !== 1 || first_done !== W) begin
      errors++;
      $display("FAIL ignore_start_done: got %0d pulses first at %0d, expected 1 at %0d", n_done, first_done, W);
    end
    checks++;
    if (result !== 8'h46 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_result: got %h c_out=%b expected 46 0", result, c_out);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcyc, n, held_bad;
    do_op(3'd2, 8'hA5, 8'h3C, 1'b0, lat, bcyc);
    alop = 3'd4; a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 8'h99) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b result=%h expected 1 0 99", busy, done, result);
    end
    n = 0; held_bad = 0;
    while (done !== 1'b1 && n < 40) begin
      if (result !== 8'h99) held_bad++;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n + 1 !== W + 1) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between done pulses expected %0d", n + 1, W + 1);
    end
    checks++;
    if (held_bad !== 0) begin
      errors++;
      $display("FAIL b2b_result_hold: result changed in %0d cycles, expected 0", held_bad);
    end
    checks++;
    if (result !== 8'h00 || c_out !== 1'b1 || zero !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got result=%h c_out=%b zero=%b expected 00 1 1", result, c_out, zero);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcyc, n_done;
    do_op(3'd1, 8'h11, 8'h22, 1'b0, lat, bcyc);
    @(posedge clk); #1;
    alop = 3'd4; a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, c_out, zero} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b result=%h c_out=%b zero=%b, all must be 0",
               busy, done, result, c_out, zero);
    end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: saw activity in %0d cycles, expected 0", n_done);
    end
    do_op(3'd4, 8'h0F, 8'h01, 1'b1, lat, bcyc);
    checks++;
    if (lat !== W || result !== 8'h11 || c_out !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_op: lat=%0d result=%h c_out=%b zero=%b expected %0d 11 0 0",
               lat, result, c_out, zero, W);
    end
  endtask

  task automatic test_random;
    int lat, bcyc;
    logic [2:0]   op;
    logic [W-1:0] av, bv;
    logic         cin;
    logic [W:0]   exp_v;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom); av = W'($urandom); bv = W'($urandom); cin = 1'($urandom);
      exp_v = model(op, av, bv, cin);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      do_op(op, av, bv, cin, lat, bcyc);
      checks++;
      if (lat !== W) begin
        errors++;
        $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, W);
      end
      checks++;
      if (result !== exp_v[W-1:0]) begin
        errors++;
        $display("FAIL rand%0d_result: op=%0d a=%h b=%h cin=%b got %h expected %h",
                 i, op, av, bv, cin, result, exp_v[W-1:0]);
      end
      checks++;
      if (c_out !== exp_v[W]) begin
        errors++;
        $display("FAIL rand%0d_c_out: op=%0d got %b expected %b", i, op, c_out, exp_v[W]);
      end
      checks++;
      if (zero !== (exp_v[W-1:0] == '0)) begin
        errors++;
        $display("FAIL rand%0d_zero: got %b expected %b", i, zero, (exp_v[W-1:0] == '0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_boundary();
    test_sub();
    test_logic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
